// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB/JUMP with a memory-wait watchdog.
// Optional perf counters (retired_count, stall_count) are enabled by defining MCU_PERF_COUNTERS_EN.
module multicycle_control_unit #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_wren,
    output logic             pc_wren,
    output logic [2:0]       pc_control,
    output logic [3:0]       data_mem_wren,
    output logic             reg_file_wren,
    output logic             reg_file_dmux_select,
    output logic             reg_file_rmux_select,
    output logic             alu_mux_select,
    output logic [3:0]       alu_control,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_JUMP = 3'd5
    } state_t;

    localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t          r_state, w_next;
    logic [WW-1:0]   r_wait;
    logic [5:0]      w_op, w_funct;
    logic            w_is_load, w_is_sw, w_is_branch, w_is_jr, w_op_legal;
    logic            w_ready, w_waiting, w_abort, w_wait_inc;
    logic [3:0]      w_alu_op;
    logic            w_alu_ok;
    logic            w_unused_bits;

    assign w_op          = instruction[31:26];
    assign w_funct       = instruction[5:0];
    assign w_unused_bits = ^instruction[25:6];
    assign w_is_load     = (w_op == 6'h20) || (w_op == 6'h21) || (w_op == 6'h23) ||
                           (w_op == 6'h24) || (w_op == 6'h25);
    assign w_is_sw       = (w_op == 6'h2B);
    assign w_is_branch   = (w_op == 6'h04) || (w_op == 6'h05);
    assign w_is_jr       = (w_op == 6'h00) && (w_funct == 6'h08);

    // Watchdog: a ready arriving on the limit cycle takes precedence over the abort.
    assign w_ready    = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !w_ready;
    assign w_abort    = (WAIT_LIMIT != 0) && w_waiting && (r_wait == WW'(WAIT_LIMIT));
    assign w_wait_inc = w_waiting && !w_abort;

    always_comb begin
        w_op_legal = 1'b0;
        case (w_op)
            6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B: w_op_legal = 1'b1;
            default:                                  w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_op = 4'b1111;
        w_alu_ok = 1'b1;
        if (w_op == 6'h00) begin
            case (w_funct)
                6'h24: w_alu_op = 4'b0000;
                6'h25: w_alu_op = 4'b0001;
                6'h21: w_alu_op = 4'b0010;
                6'h26: w_alu_op = 4'b0011;
                6'h27: w_alu_op = 4'b0100;
                6'h23: w_alu_op = 4'b0110;
                6'h2A: w_alu_op = 4'b0111;
                6'h00: w_alu_op = 4'b1000;
                6'h02: w_alu_op = 4'b1001;
                6'h03: w_alu_op = 4'b1010;
                6'h20: w_alu_op = 4'b1011;
                6'h08: w_alu_op = 4'b1111;
                default: w_alu_ok = 1'b0;
            endcase
        end else begin
            case (w_op)
                6'h0C:                      w_alu_op = 4'b0000;
                6'h0D:                      w_alu_op = 4'b0001;
                6'h09:                      w_alu_op = 4'b0010;
                6'h0A:                      w_alu_op = 4'b0111;
                6'h04, 6'h05:               w_alu_op = 4'b1100;
                6'h08, 6'h20, 6'h21, 6'h23,
                6'h24, 6'h25, 6'h2B:        w_alu_op = 4'b1011;
                default:                    w_alu_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_next               = r_state;
        imem_req             = 1'b0;
        dmem_req             = 1'b0;
        ir_wren              = 1'b0;
        pc_wren              = 1'b0;
        pc_control           = 3'b000;
        data_mem_wren        = 4'b0000;
        reg_file_wren        = 1'b0;
        reg_file_dmux_select = 1'b0;
        reg_file_rmux_select = 1'b0;
        alu_mux_select       = 1'b0;
        alu_control          = 4'b1111;
        illegal_instr        = 1'b0;
        bus_error            = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    if (w_abort) begin
                        bus_error = 1'b1;
                        pc_wren   = 1'b1;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            ir_wren = 1'b1;
                            w_next  = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (w_op == 6'h02 || w_op == 6'h03) w_next = S_JUMP;
                    else if (w_op_legal)                w_next = S_EXEC;
                    else begin
                        illegal_instr = 1'b1;
                        pc_wren       = 1'b1;
                        w_next        = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_control    = w_alu_op;
                    // Branches compare two registers, so they keep the register operand.
                    alu_mux_select = (w_op != 6'h00) && !w_is_branch;
                    if (!w_alu_ok) begin
                        illegal_instr = 1'b1;
                        pc_wren       = 1'b1;
                        w_next        = S_FETCH;
                    end else if (w_is_branch) begin
                        pc_wren    = 1'b1;
                        pc_control = (alu_zero ^ (w_op == 6'h05)) ? 3'b011 : 3'b000;
                        w_next     = S_FETCH;
                    end else if (w_is_jr) begin
                        pc_wren    = 1'b1;
                        pc_control = 3'b010;
                        w_next     = S_FETCH;
                    end else if (w_is_load || w_is_sw) w_next = S_MEM;
                    else                                w_next = S_WB;
                end
                S_MEM: begin
                    if (w_abort) begin
                        bus_error = 1'b1;
                        pc_wren   = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        dmem_req      = 1'b1;
                        data_mem_wren = w_is_sw ? 4'b1111 : 4'b0000;
                        if (dmem_ready) begin
                            if (w_is_sw) begin
                                pc_wren = 1'b1;
                                w_next  = S_FETCH;
                            end else w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_file_wren        = 1'b1;
                    pc_wren              = 1'b1;
                    reg_file_dmux_select = !w_is_load;
                    reg_file_rmux_select = (w_op == 6'h00);
                    w_next               = S_FETCH;
                end
                S_JUMP: begin
                    pc_wren    = 1'b1;
                    pc_control = 3'b001;
                    w_next     = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    // Waiting never leaves the state, so any non-waiting cycle clears the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_inc ? r_wait + WW'(1) : '0;
        end
    end

`ifdef MCU_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_retired, r_stall;
    logic             w_retire;
    assign w_retire = pc_wren && !illegal_instr && !bus_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if (w_retire)   r_retired <= r_retired + CNT_W'(1);
            if (w_wait_inc) r_stall   <= r_stall + CNT_W'(1);
        end
    end
    assign retired_count = r_retired;
    assign stall_count   = r_stall;
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected strobes go through a scoreboard queue.
module tb_multicycle_control_unit;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst, alu_zero, imem_ready, dmem_ready;
    logic [31:0]      instruction;
    logic             imem_req, dmem_req, ir_wren, pc_wren, reg_file_wren;
    logic             reg_file_dmux_select, reg_file_rmux_select, alu_mux_select;
    logic             illegal_instr, bus_error;
    logic [2:0]       pc_control;
    logic [3:0]       data_mem_wren, alu_control;
    logic [CNT_W-1:0] retired_count, stall_count;

    multicycle_control_unit #(.WAIT_LIMIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_wren(ir_wren), .pc_wren(pc_wren),
        .pc_control(pc_control), .data_mem_wren(data_mem_wren), .reg_file_wren(reg_file_wren),
        .reg_file_dmux_select(reg_file_dmux_select), .reg_file_rmux_select(reg_file_rmux_select),
        .alu_mux_select(alu_mux_select), .alu_control(alu_control),
        .illegal_instr(illegal_instr), .bus_error(bus_error),
        .retired_count(retired_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [20:0] q_exp[$];
    string       q_tag[$];
    logic [20:0] obs;

    assign obs = {imem_req, dmem_req, ir_wren, pc_wren, pc_control, data_mem_wren, reg_file_wren,
                  reg_file_dmux_select, reg_file_rmux_select, alu_mux_select, alu_control,
                  illegal_instr, bus_error};

    function automatic logic [20:0] ev(input logic im, dm, ir, pw, input logic [2:0] pc,
                                       input logic [3:0] dw, input logic rf, dx, rx, am,
                                       input logic [3:0] ac, input logic il, be);
        return {im, dm, ir, pw, pc, dw, rf, dx, rx, am, ac, il, be};
    endfunction

    // One clock: queue the expectation, compare on the falling edge, return just after the rising edge.
    task automatic cyc(input string tag, input logic [20:0] e);
        logic [20:0] x;
        string       t;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(negedge clk);
        x = q_exp.pop_front();
        t = q_tag.pop_front();
        checks++;
        assert (obs === x) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int er, input int es);
        logic [CNT_W-1:0] xr, xs;
`ifdef MCU_PERF_COUNTERS_EN
        xr = CNT_W'(er);
        xs = CNT_W'(es);
`else
        xr = '0;
        xs = '0;
`endif
        checks += 2;
        assert (retired_count === xr) else begin
            errors++;
            $error("FAIL %s retired: observed %0d expected %0d", tag, retired_count, xr);
        end
        assert (stall_count === xs) else begin
            errors++;
            $error("FAIL %s stall: observed %0d expected %0d", tag, stall_count, xs);
        end
    endtask

    logic [20:0] E_IDLE, E_FOK, E_FWAIT, E_NEXT;
    assign E_IDLE  = ev(0,0,0,0,3'b000,4'h0,0,0,0,0,4'hF,0,0);
    assign E_FOK   = ev(1,0,1,0,3'b000,4'h0,0,0,0,0,4'hF,0,0);
    assign E_FWAIT = ev(1,0,0,0,3'b000,4'h0,0,0,0,0,4'hF,0,0);
    assign E_NEXT  = ev(0,0,0,1,3'b000,4'h0,0,0,0,0,4'hF,0,0);

    initial begin
        rst = 1'b1; alu_zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instruction = 32'h0;
        cyc("reset", E_IDLE);
        rst = 1'b0;

        // addu $3,$1,$2
        instruction = 32'h00221821; imem_ready = 1'b1;
        cyc("addu_fetch", E_FOK);
        cyc("addu_dec", E_IDLE);
        cyc("addu_exec", ev(0,0,0,0,3'b000,4'h0,0,0,0,0,4'b0010,0,0));
        cyc("addu_wb", ev(0,0,0,1,3'b000,4'h0,1,1,1,0,4'hF,0,0));

        // lw with three memory wait cycles
        instruction = 32'h8C220004;
        cyc("lw_fetch", E_FOK);
        cyc("lw_dec", E_IDLE);
        cyc("lw_exec", ev(0,0,0,0,3'b000,4'h0,0,0,0,1,4'b1011,0,0));
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", ev(0,1,0,0,3'b000,4'h0,0,0,0,0,4'hF,0,0));
        dmem_ready = 1'b1;
        cyc("lw_mem_done", ev(0,1,0,0,3'b000,4'h0,0,0,0,0,4'hF,0,0));
        cyc("lw_wb", ev(0,0,0,1,3'b000,4'h0,1,0,0,0,4'hF,0,0));
        chk_cnt("after_lw", 2, 3);

        // beq taken, then not taken
        instruction = 32'h10220003; alu_zero = 1'b1;
        cyc("beq1_fetch", E_FOK);
        cyc("beq1_dec", E_IDLE);
        cyc("beq_taken", ev(0,0,0,1,3'b011,4'h0,0,0,0,0,4'b1100,0,0));
        alu_zero = 1'b0;
        cyc("beq0_fetch", E_FOK);
        cyc("beq0_dec", E_IDLE);
        cyc("beq_not_taken", ev(0,0,0,1,3'b000,4'h0,0,0,0,0,4'b1100,0,0));

        // sw, zero-wait
        instruction = 32'hAC220008;
        cyc("sw_fetch", E_FOK);
        cyc("sw_dec", E_IDLE);
        cyc("sw_exec", ev(0,0,0,0,3'b000,4'h0,0,0,0,1,4'b1011,0,0));
        cyc("sw_mem", ev(0,1,0,1,3'b000,4'hF,0,0,0,0,4'hF,0,0));

        // j, jr, bad funct, bad opcode
        instruction = 32'h08000010;
        cyc("j_fetch", E_FOK);
        cyc("j_dec", E_IDLE);
        cyc("j_jump", ev(0,0,0,1,3'b001,4'h0,0,0,0,0,4'hF,0,0));
        instruction = 32'h03E00008;
        cyc("jr_fetch", E_FOK);
        cyc("jr_dec", E_IDLE);
        cyc("jr_exec", ev(0,0,0,1,3'b010,4'h0,0,0,0,0,4'hF,0,0));
        instruction = 32'h0000003F;
        cyc("badfn_fetch", E_FOK);
        cyc("badfn_dec", E_IDLE);
        cyc("badfn_exec", ev(0,0,0,1,3'b000,4'h0,0,0,0,0,4'hF,1,0));
        instruction = 32'hFC000000;
        cyc("badop_fetch", E_FOK);
        cyc("badop_dec", ev(0,0,0,1,3'b000,4'h0,0,0,0,0,4'hF,1,0));
        chk_cnt("after_illegal", 7, 3);

        // imem stuck: watchdog abort after four wait cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("stuck_wait", E_FWAIT);
        cyc("bus_error", ev(0,0,0,1,3'b000,4'h0,0,0,0,0,4'hF,0,1));
        // ready on the limit cycle wins over the abort
        instruction = 32'h08000010;
        for (int i = 0; i < 4; i++) cyc("rewait", E_FWAIT);
        imem_ready = 1'b1;
        cyc("ready_wins", E_FOK);
        cyc("rj_dec", E_IDLE);
        cyc("rj_jump", ev(0,0,0,1,3'b001,4'h0,0,0,0,0,4'hF,0,0));
        chk_cnt("after_watchdog", 8, 11);

        // reset during S_MEM of sw drops the write
        instruction = 32'hAC220008; dmem_ready = 1'b0;
        cyc("rsw_fetch", E_FOK);
        cyc("rsw_dec", E_IDLE);
        cyc("rsw_exec", ev(0,0,0,0,3'b000,4'h0,0,0,0,1,4'b1011,0,0));
        rst = 1'b1;
        cyc("rst_in_mem", E_IDLE);
        rst = 1'b0; imem_ready = 1'b0;
        chk_cnt("after_rst", 0, 0);
        cyc("post_rst_fetch", E_FWAIT);
        imem_ready = 1'b1;
        cyc("post_rst_fetch_ok", E_FOK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- It handshakes with instruction and data memories that have variable latency.
- It drives the existing datapath selects (reg_file muxes, alu_mux, alu_control, pc_control) plus the new IR and PC write strobes.
- It sits between the IR/PC registers, the ALU and both memory ports.

Parameters:
- WAIT_LIMIT, 16: maximum cycles to wait for imem_ready or dmem_ready before aborting with bus_error. 0 disables the watchdog.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instruction  input  32  current IR contents.
- alu_zero  input  1  ALU zero flag, valid in EXECUTE.
- imem_ready  input  1  instruction memory has valid data this cycle.
- dmem_ready  input  1  data memory access completes this cycle.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data memory access request.
- ir_wren  output  1  load IR from instruction memory.
- pc_wren  output  1  update PC per pc_control.
- pc_control  output  3  000 PC+4, 001 jump target, 010 register (jr), 011 branch target.
- data_mem_wren  output  4  byte write enables.
- reg_file_wren  output  1  register file write.
- reg_file_dmux_select  output  1  0 = memory data, 1 = ALU result.
- reg_file_rmux_select  output  1  1 = rd destination, 0 = rt destination.
- alu_mux_select  output  1  1 = immediate operand, 0 = register operand.
- alu_control  output  4  ALU operation code.
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode.
- bus_error  output  1  one-cycle pulse on a watchdog abort.
- retired_count  output  CNT_W  instructions retired (optional feature).
- stall_count  output  CNT_W  cycles spent waiting on memory (optional feature).

Behaviour:
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_JUMP=5. The state is registered; outputs are combinational from the state and instruction.
- While rst=1: all strobes (imem_req, dmem_req, ir_wren, pc_wren, reg_file_wren, data_mem_wren, illegal_instr, bus_error) are forced to 0 in the same cycle, and alu_control=1111. The next edge sets state=S_FETCH and clears the wait counter and perf counters. Reset mid-access abandons the access with no write.
- Default outside any listed state: all strobes 0, pc_control=000, alu_control=1111.
- S_FETCH: imem_req=1.
  - If imem_ready: ir_wren=1, go to S_DECODE.
  - Else stay in S_FETCH.
- S_DECODE: no strobes.
  - op 2/3 (j/jal): go to S_JUMP.
  - op 0, 4, 5, 8, 9, A, C, D, 20, 21, 23, 24, 25, 2B: go to S_EXEC.
  - Any other op: illegal_instr=1, pc_wren=1, pc_control=000, go to S_FETCH (instruction skipped).
- S_EXEC: alu_control uses the team ALU encoding:
  - AND/andi=0000, OR/ori=0001, addu/addiu=0010, XOR=0011, NOR=0100, subu=0110, slt/slti=0111, sll=1000, srl=1001, sra=1010.
  - add/addi/lw-family/sw=1011, beq/bne=1100.
  - Any other R funct: illegal_instr=1, PC+4 retire.
- S_EXEC selects and transitions:
  - alu_mux_select = 1 for I-format, else 0.
  - beq: pc_wren=1. pc_control=011 if alu_zero=1, else 000. Go to S_FETCH.
  - bne: same, with the alu_zero sense inverted.
  - jr (op 0, funct 08): pc_wren=1, pc_control=010, go to S_FETCH.
  - Loads and sw: go to S_MEM.
  - All other ALU ops: go to S_WB.
- S_MEM: dmem_req=1; for sw, data_mem_wren=1111 while dmem_req is high.
  - On dmem_ready, load: go to S_WB.
  - On dmem_ready, sw: pc_wren=1, pc_control=000, go to S_FETCH.
- S_WB: reg_file_wren=1, pc_wren=1, pc_control=000, go to S_FETCH.
  - reg_file_dmux_select = 0 for loads, else 1.
  - reg_file_rmux_select = 1 for op 0, else 0.
- S_JUMP: pc_wren=1, pc_control=001, go to S_FETCH. No link register write is performed for jal.
- Wait counter:
  - Increments each cycle in S_FETCH or S_MEM while ready=0, and clears on any state change.
  - If WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT: bus_error=1 for one cycle, pc_wren=1, pc_control=000, no register or memory write, go to S_FETCH.
  - If ready and the limit coincide in the same cycle, ready wins.
- Latencies with zero-wait memory:
  - R/I ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jr: 3 cycles.
  - j/jal: 3 cycles.

Optional Feature:
- Macro MCU_PERF_COUNTERS_EN.
- When defined:
  - retired_count increments on every pc_wren cycle that is not due to illegal_instr or bus_error.
  - stall_count increments on every cycle the wait counter increments.
  - Both wrap modulo 2^CNT_W and clear on rst.
- When undefined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) with imem_ready=1 → FETCH, DECODE, EXEC, WB.
  - EXEC: alu_control=0010, alu_mux_select=0.
  - WB: reg_file_wren=1, rmux=1, dmux=1, pc_wren=1, pc_control=000.
  - Total 4 cycles.
- lw (0x8C220004), dmem_ready delayed 3 cycles → dmem_req held 4 cycles; WB with dmux=0, rmux=0.
  - Total 8 cycles; stall_count=3 when the feature is enabled.
- beq (0x10220003): alu_zero=1 → pc_control=011 in EXEC; alu_zero=0 → pc_control=000. 3 cycles each.
- sw (0xAC220008) → data_mem_wren=1111 only during S_MEM, reg_file_wren never asserted, 4 cycles.
- Opcode 0x3F, then WAIT_LIMIT=4 with imem_ready stuck at 0:
  - 0x3F: illegal_instr pulses in DECODE.
  - Stuck ready: bus_error pulses after 4 wait cycles, FSM returns to S_FETCH.
- rst asserted during S_MEM of a sw → data_mem_wren=0 in that cycle; FETCH on the next cycle, counters zero.
